// File: rtl/subtractor_xxbit_serial_seq.sv
// Nibble-serial subtractor: o_res = a - b - brw, one 4-bit slice per clock,
// with operand and result valid/ready handshakes around a three-state FSM.
module subtractor_xxbit_serial_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_brw,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_brw,
    output logic                  o_ovf
);

    localparam int N   = DATA_WIDTH / 4;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int MSB = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  brw_q, brw_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] o_res_q, o_res_d;
    logic                  o_brw_q, o_brw_d;
    logic                  o_ovf_q, o_ovf_d;

    logic [CW+1:0]         idx_s;
    logic                  last_s;
    logic [4:0]            slice_sum_s;

    // A borrow-in of 1 becomes a carry-in of 0 in a + ~b + ~brw.
    assign idx_s       = {cnt_q, 2'b00};
    assign last_s      = (cnt_q == CW'(N - 1));
    assign slice_sum_s = {1'b0, a_q[idx_s +: 4]} + {1'b0, ~b_q[idx_s +: 4]} + {4'b0000, ~brw_q};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_valid) state_d = BUSY;
                else         state_d = IDLE;
            end
            BUSY: begin
                if (last_s) state_d = DONE;
                else        state_d = BUSY;
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
                else         state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        o_ready = (state_q == IDLE);
        o_valid = (state_q == DONE);
    end

    assign o_res = o_res_q;
    assign o_brw = o_brw_q;
    assign o_ovf = o_ovf_q;

    // Datapath next values: operand capture, slice computation, result load
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        o_res_d = o_res_q;
        o_brw_d = o_brw_q;
        o_ovf_d = o_ovf_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d   = i_num_a;
                    b_d   = i_num_b;
                    brw_d = i_brw;
                    res_d = {DATA_WIDTH{1'b0}};
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            BUSY: begin
                res_d[idx_s +: 4] = slice_sum_s[3:0];
                brw_d             = ~slice_sum_s[4];
                cnt_d             = cnt_q + CW'(1);
                if (last_s) begin
                    o_res_d = res_d;
                    o_brw_d = ~slice_sum_s[4];
                    o_ovf_d = (a_q[MSB] != b_q[MSB]) && (res_d[MSB] != a_q[MSB]);
                end else begin
                    o_res_d = o_res_q;
                end
            end
            DONE:    cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q     <= {DATA_WIDTH{1'b0}};
            b_q     <= {DATA_WIDTH{1'b0}};
            res_q   <= {DATA_WIDTH{1'b0}};
            brw_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            o_res_q <= {DATA_WIDTH{1'b0}};
            o_brw_q <= 1'b0;
            o_ovf_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            o_res_q <= o_res_d;
            o_brw_q <= o_brw_d;
            o_ovf_q <= o_ovf_d;
        end
    end

endmodule

// File: tb/tb_subtractor_xxbit_serial_seq.sv
// Self-checking bench: W=8, W=16 and W=4 instances checked against an
// arithmetic reference model with directed and random operations.
module tb_subtractor_xxbit_serial_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  valid_v, ready_v, brw_v;
    logic [15:0] a_s [3];
    logic [15:0] b_s [3];
    logic [2:0]  ovalid_v, oready_v, obrw_v, oovf_v;
    logic [7:0]  res8;
    logic [15:0] res16;
    logic [3:0]  res4;
    logic [15:0] res_s [3];

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    assign res_s[0] = {8'h00, res8};
    assign res_s[1] = res16;
    assign res_s[2] = {12'h000, res4};

    always @(posedge clk) cyc <= cyc + 1;

    subtractor_xxbit_serial_seq #(.DATA_WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_v[0]), .o_ready(oready_v[0]),
        .i_num_a(a_s[0][7:0]), .i_num_b(b_s[0][7:0]), .i_brw(brw_v[0]),
        .o_valid(ovalid_v[0]), .i_ready(ready_v[0]), .o_res(res8),
        .o_brw(obrw_v[0]), .o_ovf(oovf_v[0]));

    subtractor_xxbit_serial_seq #(.DATA_WIDTH(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_v[1]), .o_ready(oready_v[1]),
        .i_num_a(a_s[1]), .i_num_b(b_s[1]), .i_brw(brw_v[1]),
        .o_valid(ovalid_v[1]), .i_ready(ready_v[1]), .o_res(res16),
        .o_brw(obrw_v[1]), .o_ovf(oovf_v[1]));

    subtractor_xxbit_serial_seq #(.DATA_WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_v[2]), .o_ready(oready_v[2]),
        .i_num_a(a_s[2][3:0]), .i_num_b(b_s[2][3:0]), .i_brw(brw_v[2]),
        .o_valid(ovalid_v[2]), .i_ready(ready_v[2]), .o_res(res4),
        .o_brw(obrw_v[2]), .o_ovf(oovf_v[2]));

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int wid(input int u);
        case (u)
            0:       return 8;
            1:       return 16;
            default: return 4;
        endcase
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bi,
                         output logic [15:0] er, output logic eb, output logic eo);
        longint mask, half, am, bm, d, sa, sb, sd;
        mask = (64'sd1 <<< w) - 1;
        half = 64'sd1 <<< (w - 1);
        am   = longint'(a) & mask;
        bm   = longint'(b) & mask;
        d    = am - bm - (bi ? 64'sd1 : 64'sd0);
        er   = 16'(d & mask);
        eb   = (d < 0);
        sa   = (am >= half) ? am - 2 * half : am;
        sb   = (bm >= half) ? bm - 2 * half : bm;
        sd   = sa - sb - (bi ? 64'sd1 : 64'sd0);
        eo   = (sd < -half) || (sd > half - 1);
    endtask

    task automatic run_op(input int u, input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input int bp, input string tag, output int unsigned acc);
        int          w;
        int          n;
        logic [15:0] er;
        logic        eb, eo;
        w = wid(u);
        n = w / 4;
        model(w, a, b, bi, er, eb, eo);
        check1({tag, ".idle_ready"}, oready_v[u], 1'b1);
        valid_v[u] = 1'b1;
        a_s[u]     = a;
        b_s[u]     = b;
        brw_v[u]   = bi;
        ready_v[u] = (bp == 0);
        tick();
        acc        = cyc;
        valid_v[u] = 1'b0;
        a_s[u]     = 16'($urandom);
        b_s[u]     = 16'($urandom);
        brw_v[u]   = 1'($urandom);
        check1({tag, ".busy_ready"}, oready_v[u], 1'b0);
        for (int k = 1; k <= n; k++) begin
            tick();
            check1({tag, ".valid_timing"}, ovalid_v[u], (k == n));
        end
        check16({tag, ".res"}, res_s[u], er);
        check1({tag, ".brw"}, obrw_v[u], eb);
        check1({tag, ".ovf"}, oovf_v[u], eo);
        for (int k = 0; k < bp; k++) begin
            valid_v[u] = 1'($urandom);
            a_s[u]     = 16'($urandom);
            b_s[u]     = 16'($urandom);
            tick();
            check1({tag, ".bp_valid"}, ovalid_v[u], 1'b1);
            check1({tag, ".bp_ready"}, oready_v[u], 1'b0);
            check16({tag, ".bp_res"}, res_s[u], er);
            check1({tag, ".bp_brw"}, obrw_v[u], eb);
            check1({tag, ".bp_ovf"}, oovf_v[u], eo);
        end
        valid_v[u] = 1'b0;
        ready_v[u] = 1'b1;
        tick();
        ready_v[u] = 1'b0;
        check1({tag, ".consumed_valid"}, ovalid_v[u], 1'b0);
        check1({tag, ".consumed_ready"}, oready_v[u], 1'b1);
        check16({tag, ".hold_res"}, res_s[u], er);
    endtask

    initial begin
        int unsigned c1, c2, c3;
        rst     = 1'b1;
        valid_v = 3'b000;
        ready_v = 3'b000;
        brw_v   = 3'b000;
        for (int u = 0; u < 3; u++) begin
            a_s[u] = 16'h0000;
            b_s[u] = 16'h0000;
        end
        repeat (2) tick();
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            check1("reset.ready", oready_v[u], 1'b1);
            check1("reset.valid", ovalid_v[u], 1'b0);
            check16("reset.res", res_s[u], 16'h0000);
            check1("reset.brw", obrw_v[u], 1'b0);
            check1("reset.ovf", oovf_v[u], 1'b0);
        end

        run_op(0, 16'h005A, 16'h0023, 1'b0, 0, "w8_basic", c1);
        check16("w8_basic.const", res_s[0], 16'h0037);
        run_op(0, 16'h0000, 16'h0001, 1'b0, 0, "w8_underflow", c1);
        check1("w8_underflow.const_brw", obrw_v[0], 1'b1);
        run_op(0, 16'h0080, 16'h0001, 1'b0, 0, "w8_ovf", c1);
        check1("w8_ovf.const_ovf", oovf_v[0], 1'b1);
        run_op(0, 16'h0010, 16'h000F, 1'b1, 0, "w8_brwin", c1);
        check16("w8_brwin.const", res_s[0], 16'h0000);

        run_op(1, 16'h1234, 16'h0235, 1'b0, 0, "w16_a", c1);
        check16("w16_a.const", res_s[1], 16'h0FFF);
        run_op(1, 16'h8000, 16'h7FFF, 1'b1, 0, "w16_b", c2);
        check16("w16.accept_spacing", 16'(c2 - c1), 16'd6);

        run_op(0, 16'h00C3, 16'h0047, 1'b1, 5, "w8_backpressure", c1);

        // Reset after two slices of a 16-bit operation
        valid_v[1] = 1'b1;
        a_s[1]     = 16'hABCD;
        b_s[1]     = 16'h1234;
        brw_v[1]   = 1'b1;
        tick();
        valid_v[1] = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("midrst.valid", ovalid_v[1], 1'b0);
        check1("midrst.ready", oready_v[1], 1'b1);
        check16("midrst.res", res_s[1], 16'h0000);
        check1("midrst.brw", obrw_v[1], 1'b0);
        check1("midrst.ovf", oovf_v[1], 1'b0);
        run_op(1, 16'hFFFF, 16'h0001, 1'b0, 0, "midrst.next", c3);
        check16("midrst.next_const", res_s[1], 16'hFFFE);

        run_op(2, 16'h0003, 16'h0005, 1'b0, 0, "w4_a", c1);
        run_op(2, 16'h0008, 16'h0001, 1'b1, 2, "w4_b", c2);
        check16("w4.accept_spacing", 16'(c2 - c1), 16'd3);

        for (int i = 0; i < 24; i++) begin
            run_op(int'($urandom_range(0, 2)), 16'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), "rand", c1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/subtractor_xxbit_serial_seq.md
# subtractor_xxbit_serial_seq

Multi-cycle nibble-serial subtractor: the inverse operation of the team's 4-bit-slice lookahead adders, built for area-constrained datapaths. It computes `o_res = i_num_a - i_num_b - i_brw` one 4-bit slice per clock, using `a + ~b + ~borrow` with a single registered borrow between slices. Operands enter through a valid/ready handshake and results leave through a second valid/ready handshake. It sits between an operand-producing stage and a result-consuming stage, replacing a wide combinational subtractor.

## Interface
- `DATA_WIDTH`, default 8: operand/result width; must be a multiple of 4 and ≥ 4. N = DATA_WIDTH/4 slices.
- `i_clk` input 1: clock, rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_valid` input 1: operands present on `i_num_a`, `i_num_b`, `i_brw`.
- `o_ready` output 1: block can accept operands.
- `i_num_a` input DATA_WIDTH: minuend.
- `i_num_b` input DATA_WIDTH: subtrahend.
- `i_brw` input 1: borrow into the lowest bit.
- `o_valid` output 1: result available.
- `i_ready` input 1: consumer accepts the result.
- `o_res` output DATA_WIDTH: difference, modulo 2^DATA_WIDTH.
- `o_brw` output 1: borrow out of the highest bit (1 when unsigned a < b + brw).
- `o_ovf` output 1: two's-complement signed overflow.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
  - `o_ready` = (state == IDLE).
  - `o_valid` = (state == DONE).
- **IDLE:** on `i_valid && o_ready`, the block latches a, b and `i_brw` into work registers, clears the slice counter to 0, and goes to BUSY. Otherwise it stays in IDLE.
- **BUSY:** each cycle computes slice k (bits 4k+3:4k):
  - `{c, d} = a[k] + ~b[k] + !brw`.
  - The slice result is written to result bits 4k+3:4k.
  - The borrow register gets !c.
  - The counter increments.
- **BUSY → DONE:** when k = N−1, the cycle that computes slice N−1 also:
  - loads `o_res` with the full result;
  - loads `o_brw` with the final borrow;
  - loads `o_ovf` with (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]), using the latched operands;
  - moves the state to DONE.
- **DONE:** on `i_ready`, go to IDLE. Otherwise hold.
- Output registers:
  - `o_res`, `o_brw` and `o_ovf` update only on the BUSY→DONE transition.
  - They hold their values through IDLE and BUSY until the next update or reset.
- Input changes after acceptance have no effect, because operands are latched.
- `i_valid` in BUSY or DONE is ignored and no operand is captured.
- `i_ready` outside DONE is ignored.
- No overlap between operations: a new operand is never accepted in the same cycle a result is consumed.

## Timing
- **Reset:** at a rising edge with `i_rst` = 1, the next state is IDLE, regardless of current state (including mid-BUSY or DONE). Any in-flight operation is discarded.
- **Register values after the reset edge:**
  - `o_ready` = 1, `o_valid` = 0.
  - `o_res` = 0, `o_brw` = 0, `o_ovf` = 0.
  - Counter = 0, borrow register = 0, work registers = 0.
- **Latency:** acceptance at edge E0 puts the block in BUSY after E0. Slice k is computed at edge E(k+1). `o_valid` = 1 after edge EN, i.e. N cycles after the acceptance edge. For DATA_WIDTH = 8 that is 2 cycles; for 16 it is 4 cycles.
- **Consumption:** with `i_ready` held high, the result is consumed at edge E(N+1) and `o_ready` = 1 after it.
  - Next acceptance is possible at E(N+2).
  - Maximum throughput is one operation per N+2 cycles.
- **Backpressure:** while in DONE with `i_ready` = 0, `o_valid`, `o_res`, `o_brw` and `o_ovf` stay stable, and `o_ready` stays 0.
- **DATA_WIDTH = 4:** N = 1, so BUSY lasts exactly one cycle.

## Test plan
- **Basic subtract, W=8:** a=0x5A, b=0x23, brw=0 → `o_res`=0x37, `o_brw`=0, `o_ovf`=0. `o_valid` rises 2 cycles after the accept edge.
- **Unsigned underflow, W=8:** a=0x00, b=0x01, brw=0 → `o_res`=0xFF, `o_brw`=1, `o_ovf`=0.
- **Signed overflow and borrow-in, W=8:**
  - a=0x80, b=0x01, brw=0 → `o_res`=0x7F, `o_brw`=0, `o_ovf`=1.
  - a=0x10, b=0x0F, brw=1 → `o_res`=0x00, `o_brw`=0 (cross-slice borrow propagation).
- **Wide, W=16:** a=0x1234, b=0x0235, brw=0 → `o_res`=0x0FFF, `o_brw`=0, `o_valid` after 4 cycles. With `i_ready` held high, the next accept occurs exactly 6 cycles after the first.
- **Backpressure, W=8:** hold `i_ready`=0 for 5 cycles in DONE while toggling `i_valid` and the operands. Required: `o_valid`=1 and outputs unchanged throughout, `o_ready`=0, no new capture. Raise `i_ready`: IDLE next cycle.
- **Reset mid-operation, W=16:** assert `i_rst` for one cycle after 2 slices have been computed. Required: IDLE next cycle with `o_valid`=0, `o_ready`=1, `o_res`=0, `o_brw`=0, `o_ovf`=0. A following operation a=0xFFFF, b=0x0001 → `o_res`=0xFFFE, `o_brw`=0.
